// File: rtl/boa_amo_pkg.sv
// Shared types and helpers for the LR/SC reservation controller.
// The fixed typedefs describe the default configuration; modules derive their own widths.
package boa_amo_pkg;

    localparam int unsigned MAX_AWIDTH    = 64;
    localparam int unsigned AWIDTH_DEF    = 32;
    localparam int unsigned GRAN_BITS_DEF = 2;

    function automatic int unsigned age_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    localparam int unsigned AGE_W_DEF = age_width(64);

    typedef logic [AWIDTH_DEF-1:GRAN_BITS_DEF] gran_tag_t;
    typedef logic [MAX_AWIDTH-1:0]             wide_addr_t;

    typedef struct packed {
        logic                 valid;
        gran_tag_t            tag;
        logic [AGE_W_DEF-1:0] age;
    } resv_state_t;

    // Callers zero-extend both operands, so only the bits above the granule matter.
    function automatic logic gran_match(input wide_addr_t a, input wide_addr_t b,
                                        input int unsigned gran_bits);
        wide_addr_t diff;
        diff = (a ^ b) >> gran_bits;
        return diff == '0;
    endfunction

endpackage

// File: rtl/boa_amo_resv_slot.sv
// One port's reservation: valid bit, granule tag and saturating age counter.
module boa_amo_resv_slot
    import boa_amo_pkg::*;
#(
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned GRAN_BITS = GRAN_BITS_DEF,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set,
    input  logic                        clear,
    input  logic [AWIDTH-1:0]           set_addr,
    output logic                        valid,
    output logic [AWIDTH-1:GRAN_BITS]   tag
);

    localparam int unsigned     AGE_W   = age_width(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic                      valid_q, valid_d;
    logic [AWIDTH-1:GRAN_BITS] tag_q, tag_d;
    logic [AGE_W-1:0]          age_q, age_d;
    logic                      expire;

    always_comb begin
        expire  = 1'b0;
        valid_d = valid_q;
        tag_d   = tag_q;
        age_d   = age_q;
        // Age lags the LR cycle by one, so retiring at TIMEOUT-2 drops valid TIMEOUT cycles after the LR.
        if (TIMEOUT > 0) begin
            expire = valid_q && ((32'(age_q) + 32'd2) >= TIMEOUT);
        end
        if (valid_q && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end
        if (clear || expire) begin
            valid_d = 1'b0;
        end
        if (set) begin
            valid_d = 1'b1;
            tag_d   = set_addr[AWIDTH-1:GRAN_BITS];
            age_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            age_q   <= age_d;
        end
    end

    assign valid = valid_q;
    assign tag   = tag_q;

endmodule

// File: rtl/boa_amo_resv_ctl.sv
// LR/SC reservation controller for PORTS memory ports: cross-port invalidation,
// lowest-index-wins SC arbitration and registered SC verdicts.
module boa_amo_resv_ctl
    import boa_amo_pkg::*;
#(
    parameter int unsigned PORTS     = 2,
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned GRAN_BITS = GRAN_BITS_DEF,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              lr_req,
    input  logic [PORTS-1:0][AWIDTH-1:0]  lr_addr,
    input  logic [PORTS-1:0]              sc_req,
    input  logic [PORTS-1:0][AWIDTH-1:0]  sc_addr,
    output logic [PORTS-1:0]              sc_ack,
    output logic [PORTS-1:0]              sc_ok,
    input  logic [PORTS-1:0]              watch_we,
    input  logic [PORTS-1:0][AWIDTH-1:0]  watch_addr,
    output logic [PORTS-1:0]              resv_valid
);

    function automatic logic same_granule(input logic [AWIDTH-1:0] a, input logic [AWIDTH-1:0] b);
        return gran_match(wide_addr_t'(a), wide_addr_t'(b), GRAN_BITS);
    endfunction

    logic [PORTS-1:0]              slot_valid, slot_set, slot_clear, grant;
    logic [AWIDTH-1:GRAN_BITS]     slot_tag  [PORTS];
    logic [AWIDTH-1:0]             resv_addr [PORTS];
    logic [PORTS-1:0]              sc_ack_q, sc_ack_d, sc_ok_q, sc_ok_d;
    logic                          hit_tag, hit_lr, lower_won;

    always_comb begin
        grant      = '0;
        slot_set   = '0;
        slot_clear = '0;
        hit_tag    = 1'b0;
        hit_lr     = 1'b0;
        lower_won  = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            resv_addr[i] = AWIDTH'(slot_tag[i]) << GRAN_BITS;
        end
        for (int unsigned i = 0; i < PORTS; i++) begin
            hit_tag   = 1'b0;
            hit_lr    = 1'b0;
            lower_won = 1'b0;
            for (int unsigned j = 0; j < PORTS; j++) begin
                if (j != i && watch_we[j]) begin
                    if (same_granule(watch_addr[j], resv_addr[i])) hit_tag = 1'b1;
                    if (same_granule(watch_addr[j], lr_addr[i]))   hit_lr  = 1'b1;
                end
            end
            for (int unsigned j = 0; j < i; j++) begin
                if (grant[j] && same_granule(sc_addr[j], sc_addr[i])) lower_won = 1'b1;
            end
            grant[i]      = sc_req[i] && slot_valid[i] && same_granule(sc_addr[i], resv_addr[i])
                            && !hit_tag && !lower_won;
            slot_set[i]   = lr_req[i] && !hit_lr;
            // An LR blocked by a store still relinquishes the previous reservation.
            slot_clear[i] = sc_req[i] || lr_req[i] || hit_tag;
        end
        for (int unsigned i = 0; i < PORTS; i++) begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                if (j != i && grant[j] && same_granule(sc_addr[j], resv_addr[i])) slot_clear[i] = 1'b1;
            end
        end
        sc_ack_d = sc_req;
        sc_ok_d  = grant;
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_slot
        boa_amo_resv_slot #(
            .AWIDTH    (AWIDTH),
            .GRAN_BITS (GRAN_BITS),
            .TIMEOUT   (TIMEOUT)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .set      (slot_set[g]),
            .clear    (slot_clear[g]),
            .set_addr (lr_addr[g]),
            .valid    (slot_valid[g]),
            .tag      (slot_tag[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_ack_q <= '0;
            sc_ok_q  <= '0;
        end else begin
            sc_ack_q <= sc_ack_d;
            sc_ok_q  <= sc_ok_d;
        end
    end

    assign sc_ack     = sc_ack_q;
    assign sc_ok      = sc_ok_q;
    assign resv_valid = slot_valid;

endmodule

// File: tb/tb_boa_amo_resv_ctl.sv
// Scoreboard bench: a 2-port word-granule instance with TIMEOUT=8 and a
// 4-port 64-byte-granule instance with expiry disabled.
module tb_boa_amo_resv_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_c;
    logic [1:0]        a_lr_req, a_sc_req, a_watch_we, a_sc_ack, a_sc_ok, a_resv_valid;
    logic [1:0][31:0]  a_lr_addr, a_sc_addr, a_watch_addr;
    logic [3:0]        c_lr_req, c_sc_req, c_watch_we, c_sc_ack, c_sc_ok, c_resv_valid;
    logic [3:0][31:0]  c_lr_addr, c_sc_addr, c_watch_addr;

    boa_amo_resv_ctl #(.PORTS(2), .AWIDTH(32), .GRAN_BITS(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst_a),
        .lr_req(a_lr_req), .lr_addr(a_lr_addr),
        .sc_req(a_sc_req), .sc_addr(a_sc_addr),
        .sc_ack(a_sc_ack), .sc_ok(a_sc_ok),
        .watch_we(a_watch_we), .watch_addr(a_watch_addr),
        .resv_valid(a_resv_valid)
    );

    boa_amo_resv_ctl #(.PORTS(4), .AWIDTH(32), .GRAN_BITS(6), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst(rst_c),
        .lr_req(c_lr_req), .lr_addr(c_lr_addr),
        .sc_req(c_sc_req), .sc_addr(c_sc_addr),
        .sc_ack(c_sc_ack), .sc_ok(c_sc_ok),
        .watch_we(c_watch_we), .watch_addr(c_watch_addr),
        .resv_valid(c_resv_valid)
    );

    typedef struct { string name; logic [11:0] exp; } sb_t;
    sb_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Expected vectors: {sc_ack, sc_ok, resv_valid}, each PORTS bits wide.
    typedef struct {
        logic [1:0] lr, sc, we;
        logic [1:0][31:0] la, sa, wa;
        logic [5:0] exp;
    } row_a_t;

    typedef struct {
        logic [3:0] lr, sc, we;
        logic [3:0][31:0] la, sa, wa;
        logic [11:0] exp;
    } row_c_t;

    function automatic row_a_t ra(input logic [1:0] lr, input logic [1:0] sc, input logic [1:0] we,
                                  input logic [31:0] la0, input logic [31:0] la1,
                                  input logic [31:0] sa0, input logic [31:0] sa1,
                                  input logic [31:0] wa0, input logic [31:0] wa1,
                                  input logic [5:0] exp);
        row_a_t r;
        r.lr = lr; r.sc = sc; r.we = we;
        r.la = {la1, la0}; r.sa = {sa1, sa0}; r.wa = {wa1, wa0};
        r.exp = exp;
        return r;
    endfunction

    function automatic row_c_t rc(input logic [3:0] lr, input logic [3:0] sc, input logic [3:0] we,
                                  input logic [3:0][31:0] la, input logic [3:0][31:0] sa,
                                  input logic [3:0][31:0] wa, input logic [11:0] exp);
        row_c_t r;
        r.lr = lr; r.sc = sc; r.we = we; r.la = la; r.sa = sa; r.wa = wa; r.exp = exp;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input row_a_t r, input string name);
        sb_t e;
        a_lr_req = r.lr; a_sc_req = r.sc; a_watch_we = r.we;
        a_lr_addr = r.la; a_sc_addr = r.sa; a_watch_addr = r.wa;
        e.name = name; e.exp = {6'b0, r.exp};
        sb.push_back(e);
    endtask

    task automatic drive_c(input row_c_t r, input string name);
        sb_t e;
        c_lr_req = r.lr; c_sc_req = r.sc; c_watch_we = r.we;
        c_lr_addr = r.la; c_sc_addr = r.sa; c_watch_addr = r.wa;
        e.name = name; e.exp = r.exp;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        sb_t e;
        rst_a = 1'b1; rst_c = 1'b1;
        drive_a(ra(2'b11, 2'b11, 2'b00, 32'h10, 32'h20, 32'h10, 32'h20, 0, 0, 6'b0), "reset_a");
        drive_c(rc(4'hF, 4'hF, 4'h0, '0, '0, '0, 12'b0), "reset_c");
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
        end
        a_lr_req = '0; a_sc_req = '0; c_lr_req = '0; c_sc_req = '0;
        tick();
        rst_a = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_lr_sc();
        row_a_t rows[$];
        sb_t e;
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 32'h27, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'h24, 0, 0, 0, 6'b01_01_00));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_00));
        // sc_req held for two cycles: only the first may succeed
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 32'hA0, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'hA0, 0, 0, 0, 6'b01_01_00));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'hA0, 0, 0, 0, 6'b01_00_00));
        // LR and SC together: SC judged on old reservation, LR installs new
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 32'h80, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b01, 2'b01, 2'b00, 32'h90, 0, 32'h80, 0, 0, 0, 6'b01_01_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'h90, 0, 0, 0, 6'b01_01_00));
        foreach (rows[k]) begin
            drive_a(rows[k], $sformatf("lr_sc[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
            end
        end
    endtask

    task automatic test_store_invalidate();
        row_a_t rows[$];
        sb_t e;
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 39, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 39, 6'b00_00_00));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 39, 0, 0, 0, 6'b01_00_00));
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 39, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 39, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 39, 0, 0, 0, 6'b01_01_00));
        // foreign store to a neighbouring granule leaves the reservation alone
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 39, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 43, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 38, 0, 0, 0, 6'b01_01_00));
        // SC in the same cycle as a conflicting foreign store fails
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 39, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b01, 2'b10, 0, 0, 39, 0, 0, 36, 6'b01_00_00));
        foreach (rows[k]) begin
            drive_a(rows[k], $sformatf("store_inval[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
            end
        end
    endtask

    task automatic test_sc_arbitration();
        row_a_t rows[$];
        sb_t e;
        rows.push_back(ra(2'b11, 2'b00, 2'b00, 39, 39, 0, 0, 0, 0, 6'b00_00_11));
        rows.push_back(ra(2'b00, 2'b11, 2'b00, 0, 0, 39, 39, 0, 0, 6'b11_01_00));
        rows.push_back(ra(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 0, 0, 0, 0, 6'b00_00_11));
        rows.push_back(ra(2'b00, 2'b11, 2'b00, 0, 0, 32'h10, 32'h20, 0, 0, 6'b11_11_00));
        // granted SC wipes the other port's reservation on that granule
        rows.push_back(ra(2'b11, 2'b00, 2'b00, 32'h40, 32'h40, 0, 0, 0, 0, 6'b00_00_11));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'h40, 0, 0, 0, 6'b01_01_00));
        rows.push_back(ra(2'b00, 2'b10, 2'b00, 0, 0, 0, 32'h40, 0, 0, 6'b10_00_00));
        // failed SC does not invalidate others
        rows.push_back(ra(2'b11, 2'b00, 2'b00, 32'h50, 32'h60, 0, 0, 0, 0, 6'b00_00_11));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'h60, 0, 0, 0, 6'b01_00_10));
        rows.push_back(ra(2'b00, 2'b10, 2'b00, 0, 0, 0, 32'h60, 0, 0, 6'b10_10_00));
        // lower port requesting without a reservation does not block port 1
        rows.push_back(ra(2'b10, 2'b00, 2'b00, 0, 32'h70, 0, 0, 0, 0, 6'b00_00_10));
        rows.push_back(ra(2'b00, 2'b11, 2'b00, 0, 0, 32'h70, 32'h70, 0, 0, 6'b11_10_00));
        foreach (rows[k]) begin
            drive_a(rows[k], $sformatf("arb[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
            end
        end
    endtask

    task automatic test_lr_vs_store();
        row_a_t rows[$];
        sb_t e;
        rows.push_back(ra(2'b10, 2'b00, 2'b01, 0, 69, 0, 0, 69, 0, 6'b00_00_00));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_00));
        rows.push_back(ra(2'b10, 2'b00, 2'b10, 0, 69, 0, 0, 0, 69, 6'b00_00_10));
        rows.push_back(ra(2'b00, 2'b10, 2'b00, 0, 0, 0, 69, 0, 0, 6'b10_10_00));
        foreach (rows[k]) begin
            drive_a(rows[k], $sformatf("lr_vs_store[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
            end
        end
    endtask

    task automatic test_expiry();
        row_a_t rows[$];
        sb_t e;
        rows.push_back(ra(2'b01, 2'b00, 2'b00, 32'h44, 0, 0, 0, 0, 0, 6'b00_00_01));
        for (int n = 0; n < 6; n++) rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_01));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_00));
        rows.push_back(ra(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 6'b00_00_00));
        rows.push_back(ra(2'b00, 2'b01, 2'b00, 0, 0, 32'h44, 0, 0, 0, 6'b01_00_00));
        foreach (rows[k]) begin
            drive_a(rows[k], $sformatf("expiry[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({a_sc_ack, a_sc_ok, a_resv_valid} !== e.exp[5:0]) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {a_sc_ack, a_sc_ok, a_resv_valid}, e.exp[5:0]);
            end
        end
    endtask

    task automatic test_multi_port();
        row_c_t rows[$];
        sb_t e;
        rows.push_back(rc(4'hF, 4'h0, 4'h0, {32'h100, 32'h140, 32'h13C, 32'h100}, '0, '0,
                          12'b0000_0000_1111));
        rows.push_back(rc(4'h0, 4'h0, 4'h8, '0, '0, {32'h120, 32'h0, 32'h0, 32'h0},
                          12'b0000_0000_1100));
        rows.push_back(rc(4'h0, 4'hF, 4'h0, '0, {32'h100, 32'h140, 32'h13C, 32'h100}, '0,
                          12'b1111_1100_0000));
        foreach (rows[k]) begin
            drive_c(rows[k], $sformatf("multi[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
            end
        end
    endtask

    task automatic test_no_timeout();
        sb_t e;
        drive_c(rc(4'h4, 4'h0, 4'h0, {32'h0, 32'h200, 32'h0, 32'h0}, '0, '0, 12'b0000_0000_0100),
                "no_timeout_lr");
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
        end
        drive_c(rc(4'h0, 4'h0, 4'h0, '0, '0, '0, 12'b0000_0000_0100), "no_timeout_1000");
        for (int n = 0; n < 1000; n++) tick();
        e = sb.pop_front();
        n_cmp++;
        if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
        end
        drive_c(rc(4'h0, 4'h4, 4'h0, '0, {32'h0, 32'h23F, 32'h0, 32'h0}, '0, 12'b0100_0100_0000),
                "no_timeout_sc");
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
        end
    endtask

    task automatic test_reset_mid();
        row_c_t rows[$];
        sb_t e;
        rows.push_back(rc(4'h3, 4'h0, 4'h0, {32'h0, 32'h0, 32'h340, 32'h300}, '0, '0,
                          12'b0000_0000_0011));
        rows.push_back(rc(4'h0, 4'h1, 4'h0, '0, {32'h0, 32'h0, 32'h0, 32'h300}, '0, 12'b0));
        rows.push_back(rc(4'h0, 4'h2, 4'h0, '0, {32'h0, 32'h0, 32'h340, 32'h0}, '0,
                          12'b0010_0000_0000));
        foreach (rows[k]) begin
            rst_c = (k == 1);
            drive_c(rows[k], $sformatf("reset_mid[%0d]", k));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({c_sc_ack, c_sc_ok, c_resv_valid} !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, {c_sc_ack, c_sc_ok, c_resv_valid}, e.exp);
            end
        end
        rst_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_c = 1'b1;
        a_lr_req = '0; a_sc_req = '0; a_watch_we = '0;
        a_lr_addr = '0; a_sc_addr = '0; a_watch_addr = '0;
        c_lr_req = '0; c_sc_req = '0; c_watch_we = '0;
        c_lr_addr = '0; c_sc_addr = '0; c_watch_addr = '0;
        tick();
        test_reset();
        test_lr_sc();
        test_store_invalidate();
        test_sc_arbitration();
        test_lr_vs_store();
        test_expiry();
        test_multi_port();
        test_no_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
